// File: rtl/flux_burst_arbiter.sv
// Round-robin burst arbiter: merges FLUX untagged producer streams into one {tag, data} port,
// holding each grant for up to BURST beats and dropping it after STALL_LIMIT blocked cycles.
module flux_burst_arbiter #(
   parameter  int FLUX        = 2,
   parameter  int DATA_WIDTH  = 8,
   parameter  int BURST       = 4,
   parameter  int STALL_LIMIT = 8,
   localparam int TAG_WIDTH   = $clog2(FLUX)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [FLUX*DATA_WIDTH-1:0]      src_din,
   input  logic [FLUX-1:0]                 src_valid,
   output logic [FLUX-1:0]                 src_ready,
   output logic [DATA_WIDTH+TAG_WIDTH-1:0] out_din,
   output logic                            out_write,
   input  logic [FLUX-1:0]                 out_full,
   output logic                            grant_active,
   output logic [TAG_WIDTH-1:0]            grant_id
);

   localparam int BW = $clog2(BURST + 1);
   localparam int SW = $clog2(STALL_LIMIT + 1);
   localparam logic [BW-1:0] BeatLast  = BW'(BURST - 1);
   localparam logic [SW-1:0] StallLast = SW'(STALL_LIMIT - 1);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e                state_q, state_d;
   logic [TAG_WIDTH-1:0]  grant_q, grant_d;
   logic [BW-1:0]         beat_q, beat_d;
   logic [SW-1:0]         stall_q, stall_d;

   logic [FLUX-1:0]       eligible;
   logic                  pick_found;
   logic [TAG_WIDTH-1:0]  pick_idx;
   logic [TAG_WIDTH-1:0]  cand;
   logic [DATA_WIDTH-1:0] g_data;
   logic                  g_valid;
   logic                  g_full;
   logic                  xfer;

   assign eligible = src_valid & ~out_full;

   // Scan downward so the candidate closest after grant_q is the one that sticks.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = grant_q;
      cand       = grant_q;
      for (int i = FLUX; i >= 1; i--) begin
         cand = TAG_WIDTH'((int'(grant_q) + i) % FLUX);
         if (eligible[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      g_data = '0;
      for (int f = 0; f < FLUX; f++) begin
         if (TAG_WIDTH'(f) == grant_q) begin
            g_data = src_din[f*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign g_valid = src_valid[grant_q];
   assign g_full  = out_full[grant_q];
   assign xfer    = (state_q == StGrant) && g_valid && !g_full;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      beat_d    = beat_q;
      stall_d   = stall_q;
      src_ready = '0;
      out_write = 1'b0;
      out_din   = '0;
      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               state_d = StGrant;
               grant_d = pick_idx;
               beat_d  = '0;
               stall_d = '0;
            end
         end
         StGrant: begin
            // Reset cycle must not complete a handshake that the datapath never sees.
            src_ready[grant_q] = !g_full && !rst;
            out_write          = xfer && !rst;
            if (out_write) begin
               out_din = {grant_q, g_data};
            end
            if (xfer && beat_q == BeatLast) begin
               state_d = StIdle;
            end else if (!g_valid) begin
               state_d = StIdle;
            end else if (g_full) begin
               stall_d = stall_q + 1'b1;
               if (stall_q == StallLast) begin
                  state_d = StIdle;
               end
            end else begin
               beat_d  = beat_q + 1'b1;
               stall_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         grant_q <= TAG_WIDTH'(FLUX - 1);
         beat_q  <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         beat_q  <= beat_d;
         stall_q <= stall_d;
      end
   end

   assign grant_active = (state_q == StGrant);
   assign grant_id     = grant_q;

endmodule

// File: tb/tb_flux_burst_arbiter.sv
// Directed bench for flux_burst_arbiter: expected {tag, data} words and their cycles are queued
// by the stimulus and checked by an independent output monitor.
module tb_flux_burst_arbiter;

   logic        clk;
   logic        rst;
   logic [15:0] src_din;
   logic [1:0]  src_valid;
   logic [1:0]  src_ready;
   logic [8:0]  out_din;
   logic        out_write;
   logic [1:0]  out_full;
   logic        grant_active;
   logic        grant_id;

   logic [7:0]  dat [2];
   logic [1:0]  hs;
   int          cyc_cnt = 0;
   int          base = 0;
   int          total = 0;
   int          bad = 0;

   typedef struct {
      int         cyc;
      logic [8:0] word;
   } exp_t;
   exp_t sb[$];

   flux_burst_arbiter #(
      .FLUX       (2),
      .DATA_WIDTH (8),
      .BURST      (4),
      .STALL_LIMIT(8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .src_din     (src_din),
      .src_valid   (src_valid),
      .src_ready   (src_ready),
      .out_din     (out_din),
      .out_write   (out_write),
      .out_full    (out_full),
      .grant_active(grant_active),
      .grant_id    (grant_id)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   assign src_din = {dat[1], dat[0]};

   // Monitor: every write must match the next queued word in the queued cycle.
   always @(negedge clk) begin
      exp_t e;
      if (out_write) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got %h at cycle %0d, required no write",
                     out_din, cyc_cnt);
         end else begin
            e = sb.pop_front();
            if (out_din !== e.word || cyc_cnt != e.cyc) begin
               bad++;
               $display("FAIL out_word: got %h at cycle %0d, required %h at cycle %0d",
                        out_din, cyc_cnt, e.word, e.cyc);
            end
         end
      end
   end

   task automatic push(input int off, input logic [8:0] w);
      exp_t e;
      e.cyc  = base + off;
      e.word = w;
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // One clock: record handshakes, then advance each source's data after the edge.
   task automatic cyc();
      @(negedge clk);
      hs = src_valid & src_ready;
      @(posedge clk);
      #1;
      for (int f = 0; f < 2; f++) begin
         if (hs[f]) dat[f] = dat[f] + 8'd1;
      end
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      src_valid = 2'b00;
      out_full  = 2'b00;
      cyc();
      settle();
      chk("rst_grant_active", 32'(grant_active), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd1);
      chk("rst_out_write", 32'(out_write), 32'd0);
      chk("rst_src_ready", 32'(src_ready), 32'd0);
      chk("rst_out_din", 32'(out_din), 32'd0);
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      src_valid = 2'b00;
      out_full  = 2'b00;
      dat[0]    = 8'h10;
      dat[1]    = 8'h00;
      hs        = 2'b00;
      cyc();
      do_reset();

      // Single flow: bubble, 4 beats, bubble, 4 beats.
      base = cyc_cnt;
      src_valid = 2'b01;
      for (int k = 0; k < 4; k++) push(1 + k, 9'h010 + 9'(k));
      for (int k = 0; k < 4; k++) push(6 + k, 9'h014 + 9'(k));
      for (int i = 0; i < 10; i++) begin
         settle();
         chk("s1_ready1", 32'(src_ready[1]), 32'd0);
         if (i == 0 || i == 5) chk("s1_bubble", 32'(grant_active), 32'd0);
         cyc();
      end
      src_valid = 2'b00;

      // Two saturating flows alternate 0,1,0.
      do_reset();
      dat[0] = 8'hA0;
      dat[1] = 8'hB0;
      base = cyc_cnt;
      src_valid = 2'b11;
      for (int k = 0; k < 4; k++) push(1 + k, 9'h0A0 + 9'(k));
      for (int k = 0; k < 4; k++) push(6 + k, 9'h1B0 + 9'(k));
      for (int k = 0; k < 4; k++) push(11 + k, 9'h0A4 + 9'(k));
      for (int i = 0; i < 15; i++) begin
         settle();
         if (i == 2) chk("s2_gid0", 32'(grant_id), 32'd0);
         if (i == 7) chk("s2_gid1", 32'(grant_id), 32'd1);
         if (i == 5) chk("s2_bubble", 32'(grant_active), 32'd0);
         cyc();
      end
      src_valid = 2'b00;

      // Back-pressure on flux 1 for three cycles mid-burst; flux 0 waits.
      base = cyc_cnt;
      src_valid = 2'b11;
      push(1, 9'h1B4);
      push(2, 9'h1B5);
      push(6, 9'h1B6);
      push(7, 9'h1B7);
      for (int k = 0; k < 4; k++) push(9 + k, 9'h0A8 + 9'(k));
      for (int i = 0; i < 13; i++) begin
         out_full[1] = (i >= 3 && i <= 5);
         settle();
         if (i >= 3 && i <= 5) begin
            chk("s3_stall_write", 32'(out_write), 32'd0);
            chk("s3_stall_ready1", 32'(src_ready[1]), 32'd0);
         end
         if (i >= 1 && i <= 7) chk("s3_ready0", 32'(src_ready[0]), 32'd0);
         cyc();
      end
      src_valid = 2'b00;
      out_full  = 2'b00;

      // Stall timeout: flux 0 granted but blocked, flux 1 takes over after 8 cycles.
      do_reset();
      base = cyc_cnt;
      src_valid = 2'b11;
      for (int k = 0; k < 4; k++) push(10 + k, 9'h1B8 + 9'(k));
      for (int i = 0; i < 14; i++) begin
         out_full[0] = (i >= 1);
         settle();
         if (i >= 1 && i <= 8) chk("s4_blocked_write", 32'(out_write), 32'd0);
         if (i == 8) chk("s4_still_granted", 32'(grant_active), 32'd1);
         if (i == 9) chk("s4_dropped", 32'(grant_active), 32'd0);
         if (i == 11) chk("s4_gid1", 32'(grant_id), 32'd1);
         cyc();
      end
      src_valid = 2'b00;
      out_full  = 2'b00;

      // Early end: flux 0 leaves after 2 beats, flux 1 follows the bubble.
      base = cyc_cnt;
      src_valid = 2'b11;
      push(1, 9'h0AC);
      push(2, 9'h0AD);
      for (int k = 0; k < 4; k++) push(5 + k, 9'h1BC + 9'(k));
      for (int i = 0; i < 9; i++) begin
         if (i == 3) src_valid[0] = 1'b0;
         settle();
         if (i == 1) chk("s5_ready1_wait", 32'(src_ready[1]), 32'd0);
         if (i == 3) chk("s5_end_write", 32'(out_write), 32'd0);
         if (i == 4) chk("s5_idle", 32'(grant_active), 32'd0);
         cyc();
      end
      src_valid = 2'b00;

      // Reset during beat 2 of a flux 1 burst.
      base = cyc_cnt;
      src_valid = 2'b10;
      push(1, 9'h1C0);
      push(2, 9'h1C1);
      for (int k = 0; k < 4; k++) push(5 + k, 9'h0AE + 9'(k));
      for (int i = 0; i < 9; i++) begin
         if (i == 3) rst = 1'b1;
         if (i == 4) begin
            rst       = 1'b0;
            src_valid = 2'b11;
         end
         settle();
         if (i == 3) begin
            chk("s6_rst_write", 32'(out_write), 32'd0);
            chk("s6_rst_ready", 32'(src_ready), 32'd0);
         end
         if (i == 4) begin
            chk("s6_post_active", 32'(grant_active), 32'd0);
            chk("s6_post_gid", 32'(grant_id), 32'd1);
         end
         if (i == 6) chk("s6_gid0", 32'(grant_id), 32'd0);
         cyc();
      end
      src_valid = 2'b00;

      for (int i = 0; i < 3; i++) cyc();
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/flux_burst_arbiter.md
Name: flux_burst_arbiter

Overview:
- Round-robin burst scheduler that merges FLUX independent untagged producer streams onto the single tagged input port of the multi-stream HEVC datapath.
- Output word is {tag, data}; tag = source flux index.
- Honours per-flux full back-pressure from the datapath's per-flux input FIFOs.
- Holds a grant for up to BURST beats, then rotates; a stall timeout stops one blocked flux from starving the others.

Parameters:
- FLUX, 2, number of flows; must be >= 2.
- DATA_WIDTH, 8, payload width per flow.
- TAG_WIDTH, $clog2(FLUX), tag width; derived, not overridden.
- BURST, 4, maximum beats per grant; >= 1.
- STALL_LIMIT, 8, consecutive blocked cycles before a grant is dropped; >= 1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- src_din  input  FLUX*DATA_WIDTH  payloads; flux f occupies bits [f*DATA_WIDTH +: DATA_WIDTH].
- src_valid  input  FLUX  per-flux data-available.
- src_ready  output  FLUX  per-flux accept; a transfer occurs when valid and ready are both 1.
- out_din  output  DATA_WIDTH+TAG_WIDTH  {tag, data} to the datapath input port; tag in the MSBs.
- out_write  output  1  write strobe, one word per cycle.
- out_full  input  FLUX  per-flux FIFO full from the datapath.
- grant_active  output  1  1 while in GRANT state (observability).
- grant_id  output  TAG_WIDTH  current or last granted flux.

Behaviour:
- Reset: state=IDLE, grant_id=FLUX-1 (so the first search starts at flux 0), beat counter=0, stall counter=0. All outputs read 0 except grant_id=FLUX-1.
- Eligible(f) = src_valid[f] & !out_full[f].
- State IDLE:
  - src_ready=0, out_write=0.
  - If any flux is eligible: pick the first eligible flux scanning grant_id+1, grant_id+2, ... modulo FLUX.
  - Next cycle: state=GRANT, grant_id=pick, beat=0, stall=0.
  - This gives a fixed one-cycle arbitration bubble per grant.
- State GRANT, with g=grant_id:
  - src_ready[g] = !out_full[g]; all other src_ready bits are 0.
  - out_write = src_valid[g] & !out_full[g], combinational, zero latency.
  - out_din = {g, src_din[g]} while out_write=1; 0 otherwise.
- GRANT transitions, evaluated each cycle in priority order:
  1. Transfer with beat==BURST-1 -> IDLE (burst complete).
  2. src_valid[g]==0 -> IDLE; no transfer this cycle.
  3. src_valid[g]==1 and out_full[g]==1:
     - stall increments.
     - If stall==STALL_LIMIT-1 -> IDLE (timeout).
     - Otherwise stay in GRANT.
  4. Transfer with beat<BURST-1 -> beat+1, stall=0, stay in GRANT.
- On IDLE entry, grant_id keeps the last grantee, so the next search begins after it (fairness).
- A timed-out flux is only re-selected if no other flux is eligible.
- Counters are sized $clog2(BURST+1) and $clog2(STALL_LIMIT+1); they never wrap in normal operation.
- out_full of non-granted flows is ignored in GRANT; writes never go to a flux whose full is 1.
- Reset asserted mid-burst: next cycle is IDLE with reset values; the in-flight beat in the reset cycle is not written (out_write forced 0 while rst=1).
- BURST=1: every grant is a single beat followed by the IDLE bubble.
- If a source asserts valid while another flux holds the grant, it waits with ready=0; no data is lost.

Test Plan:
- Single flow: flux 0 valid continuously with data 0x10,0x11,...; flux 1 idle, no full -> after reset: 1 bubble, 4 writes 0x010..0x013 ({tag 0,data}, 9-bit), bubble, 4 more; src_ready[1]=0 throughout.
- Two flows saturating: flux 0 data 0xA0+, flux 1 data 0xB0+ -> out_din sequence 0x0A0-0x0A3, bubble, 0x1B0-0x1B3, bubble, 0x0A4...; grant_id alternates 0,1.
- Back-pressure: during flux 1 burst, out_full[1]=1 for 3 cycles after beat 2 -> out_write=0 for 3 cycles, src_ready[1]=0, then beats 3-4 complete; flux 0 data unchanged and not written.
- Stall timeout: out_full[0] held 1 with flux 0 granted, flux 1 valid -> after 8 blocked cycles grant drops, bubble, flux 1 burst of 4 issued with tag 1.
- Early end: flux 0 valid for 2 beats then low -> 2 writes, IDLE next cycle; flux 1 granted following bubble.
- Reset mid-burst: rst=1 on beat 2 of flux 1 -> out_write=0 that cycle; grant_active=0 and grant_id=1 (FLUX-1) after; first post-reset grant goes to flux 0 if valid.
